// File: rtl/pq_pkg.sv
// Shared priority-queue definitions: default widths, the default kv_t entry
// used by existing wrappers, per-slot next-state opcodes and the pq_better compare.
// No ports; imported by ra_pq_param and pq_slot.
package pq_pkg;

  localparam int PQ_KEY_W      = 8;
  localparam int PQ_VAL_W      = 8;
  localparam int PQ_DEPTH      = 8;
  localparam int PQ_MAX_FIRST  = 0;
  localparam int PQ_DROP_WORST = 0;

  // Fixed 8/8 entry kept for the older pq_if wrappers.
  typedef struct packed {
    logic [PQ_KEY_W-1:0] key;
    logic [PQ_VAL_W-1:0] val;
  } kv_t;

  typedef enum logic [1:0] {
    SLOT_HOLD = 2'd0,
    SLOT_SHL  = 2'd1,   // take the entry of slot i+1
    SLOT_SHR  = 2'd2,   // take the entry of slot i-1
    SLOT_LOAD = 2'd3    // take the incoming entry
  } slot_op_e;

  // Strict "a is better than b". Keys are zero-extended to 64 bits by callers,
  // so any KEY_W up to 64 is supported.
  function automatic logic pq_better(input logic [63:0] a, input logic [63:0] b,
                                     input logic max_first);
    return max_first ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/pq_slot.sv
// One priority-queue entry: valid/key/value registers, next-state mux and compare flag.
// Latency: state updates on the rising edge; beaten is combinational from state and new_key.
// Backpressure: none, the slot executes whatever op the top selects each cycle.
// Ports: clk/rst_n; op; new_key/new_val (incoming entry); nxt_* (slot i+1), prv_* (slot i-1);
//        valid/key/val (state); beaten (incoming key strictly better than this entry).
module pq_slot import pq_pkg::*; #(
  parameter int KEY_W     = 8,
  parameter int VAL_W     = 8,
  parameter int MAX_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [KEY_W-1:0] new_key,
  input  logic [VAL_W-1:0] new_val,
  input  logic             nxt_valid,
  input  logic [KEY_W-1:0] nxt_key,
  input  logic [VAL_W-1:0] nxt_val,
  input  logic             prv_valid,
  input  logic [KEY_W-1:0] prv_key,
  input  logic [VAL_W-1:0] prv_val,
  output logic             valid,
  output logic [KEY_W-1:0] key,
  output logic [VAL_W-1:0] val,
  output logic             beaten
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      key   <= '0;
      val   <= '0;
    end else begin
      case (slot_op_e'(op))
        SLOT_SHL: begin
          valid <= nxt_valid;
          key   <= nxt_key;
          val   <= nxt_val;
        end
        SLOT_SHR: begin
          valid <= prv_valid;
          key   <= prv_key;
          val   <= prv_val;
        end
        SLOT_LOAD: begin
          valid <= 1'b1;
          key   <= new_key;
          val   <= new_val;
        end
        default: begin
          valid <= valid;
          key   <= key;
          val   <= val;
        end
      endcase
    end
  end

  // Equal keys do not beat an existing entry, which keeps ties in arrival order.
  assign beaten = valid && pq_better(64'(new_key), 64'(key), MAX_FIRST != 0);

endmodule

// File: rtl/ra_pq_param.sv
// Parametrised register-array priority queue, sorted array with the head in slot 0.
// Latency: enq/deq/replace take effect on the edge; new head visible right after it.
// Backpressure: none; enq when full is rejected (or evicts the tail) with ovf, deq when empty gives udf.
// Ports: clk, rst_n; enq + kvi_key/kvi_val; deq; kvo_key/kvo_val (head, 0 when empty);
//        full, empty, busy (always 0), count, ovf/udf (one-cycle registered pulses).
module ra_pq_param import pq_pkg::*; #(
  parameter int KEY_W      = PQ_KEY_W,
  parameter int VAL_W      = PQ_VAL_W,
  parameter int DEPTH      = PQ_DEPTH,
  parameter int MAX_FIRST  = PQ_MAX_FIRST,
  parameter int DROP_WORST = PQ_DROP_WORST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enq,
  input  logic [KEY_W-1:0]           kvi_key,
  input  logic [VAL_W-1:0]           kvi_val,
  input  logic                       deq,
  output logic [KEY_W-1:0]           kvo_key,
  output logic [VAL_W-1:0]           kvo_val,
  output logic                       full,
  output logic                       empty,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } ent_t;

  ent_t             new_ent;
  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] beaten;
  logic [DEPTH-1:0] hit;
  logic [KEY_W-1:0] slot_key [DEPTH];
  logic [VAL_W-1:0] slot_val [DEPTH];

  logic             do_ins;
  logic             do_shl;
  logic             do_rep;
  logic             ovf_nxt;
  logic             udf_nxt;
  logic [CNT_W-1:0] count_nxt;

  assign new_ent = '{key: kvi_key, val: kvi_val};

  // hit[i]: the incoming entry belongs at or before slot i. Because the array is
  // sorted and valid slots are contiguous, hit is a thermometer code (0..0 1..1);
  // the insertion point is its first 1, so no priority encoder is needed.
  assign hit = ~slot_valid | beaten;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign busy  = 1'b0;

  assign kvo_key = slot_valid[0] ? slot_key[0] : '0;
  assign kvo_val = slot_valid[0] ? slot_val[0] : '0;

  always_comb begin
    do_ins    = 1'b0;
    do_shl    = 1'b0;
    do_rep    = 1'b0;
    ovf_nxt   = 1'b0;
    udf_nxt   = 1'b0;
    count_nxt = count;
    if (enq && deq) begin
      if (empty) begin
        do_ins    = 1'b1;
        udf_nxt   = 1'b1;
        count_nxt = CNT_W'(1);
      end else begin
        do_rep = 1'b1;
      end
    end else if (enq) begin
      if (!full) begin
        do_ins    = 1'b1;
        count_nxt = count + CNT_W'(1);
      end else begin
        ovf_nxt = 1'b1;
        // When full, hit of the tail means strictly better than the tail; the
        // right shift then pushes the tail out of the array.
        if (DROP_WORST != 0 && hit[DEPTH-1]) do_ins = 1'b1;
      end
    end else if (deq) begin
      if (empty) begin
        udf_nxt = 1'b1;
      end else begin
        do_shl    = 1'b1;
        count_nxt = count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
      udf   <= udf_nxt;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic             nxt_valid;
    logic [KEY_W-1:0] nxt_key;
    logic [VAL_W-1:0] nxt_val;
    logic             prv_valid;
    logic [KEY_W-1:0] prv_key;
    logic [VAL_W-1:0] prv_val;
    logic             hit_prv;      // insertion point strictly before slot i
    logic             rep_hit;      // replace: point at or before i in the deq-shifted array
    logic             rep_hit_prv;  // replace: point strictly before i in the shifted array
    slot_op_e         op;

    if (i == DEPTH-1) begin : g_last
      assign nxt_valid = 1'b0;
      assign nxt_key   = '0;
      assign nxt_val   = '0;
      assign rep_hit   = 1'b1;
    end else begin : g_inner_r
      assign nxt_valid = slot_valid[i+1];
      assign nxt_key   = slot_key[i+1];
      assign nxt_val   = slot_val[i+1];
      assign rep_hit   = hit[i+1];
    end

    if (i == 0) begin : g_first
      assign prv_valid   = 1'b0;
      assign prv_key     = '0;
      assign prv_val     = '0;
      assign hit_prv     = 1'b0;
      assign rep_hit_prv = 1'b0;
    end else begin : g_inner_l
      assign prv_valid   = slot_valid[i-1];
      assign prv_key     = slot_key[i-1];
      assign prv_val     = slot_val[i-1];
      assign hit_prv     = hit[i-1];
      assign rep_hit_prv = hit[i];
    end

    // Replace = deq then enq: slots before the point shift left, the point loads,
    // slots after it would shift left then right again, i.e. hold.
    always_comb begin
      op = SLOT_HOLD;
      if (do_ins) begin
        if (hit_prv)     op = SLOT_SHR;
        else if (hit[i]) op = SLOT_LOAD;
      end else if (do_shl) begin
        op = SLOT_SHL;
      end else if (do_rep) begin
        if (!rep_hit)          op = SLOT_SHL;
        else if (!rep_hit_prv) op = SLOT_LOAD;
      end
    end

    pq_slot #(
      .KEY_W     (KEY_W),
      .VAL_W     (VAL_W),
      .MAX_FIRST (MAX_FIRST)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .new_key   (new_ent.key),
      .new_val   (new_ent.val),
      .nxt_valid (nxt_valid),
      .nxt_key   (nxt_key),
      .nxt_val   (nxt_val),
      .prv_valid (prv_valid),
      .prv_key   (prv_key),
      .prv_val   (prv_val),
      .valid     (slot_valid[i]),
      .key       (slot_key[i]),
      .val       (slot_val[i]),
      .beaten    (beaten[i])
    );
  end

endmodule

// File: tb/tb_ra_pq_param.sv
// Directed bench for ra_pq_param: three instances (min-first reject, min-first
// drop-worst, max-first) with hand-computed expected heads and flags.
module tb_ra_pq_param;

  logic       clk;
  logic       rst_n;
  logic       enq, deq;
  logic [7:0] key, val;
  logic       enq2, deq2;
  logic [7:0] key2, val2;

  logic [7:0] kk0, kv0, kk1, kv1, kk2, kv2;
  logic       full0, empty0, busy0, ovf0, udf0;
  logic       full1, empty1, busy1, ovf1, udf1;
  logic       full2, empty2, busy2, ovf2, udf2;
  logic [2:0] cnt0, cnt1, cnt2;

  int errors = 0;
  int checks = 0;

  ra_pq_param #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MAX_FIRST(0), .DROP_WORST(0)) u0 (
    .clk(clk), .rst_n(rst_n), .enq(enq), .kvi_key(key), .kvi_val(val), .deq(deq),
    .kvo_key(kk0), .kvo_val(kv0), .full(full0), .empty(empty0), .busy(busy0),
    .count(cnt0), .ovf(ovf0), .udf(udf0));

  ra_pq_param #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MAX_FIRST(0), .DROP_WORST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enq(enq), .kvi_key(key), .kvi_val(val), .deq(deq),
    .kvo_key(kk1), .kvo_val(kv1), .full(full1), .empty(empty1), .busy(busy1),
    .count(cnt1), .ovf(ovf1), .udf(udf1));

  ra_pq_param #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MAX_FIRST(1), .DROP_WORST(0)) u2 (
    .clk(clk), .rst_n(rst_n), .enq(enq2), .kvi_key(key2), .kvi_val(val2), .deq(deq2),
    .kvo_key(kk2), .kvo_val(kv2), .full(full2), .empty(empty2), .busy(busy2),
    .count(cnt2), .ovf(ovf2), .udf(udf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive u0/u1 for one edge, then sample 1 time unit after it.
  task automatic op(input logic e, input logic d, input logic [7:0] k, input logic [7:0] v);
    @(negedge clk);
    enq = e; deq = d; key = k; val = v;
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0;
  endtask

  task automatic op2(input logic e, input logic d, input logic [7:0] k, input logic [7:0] v);
    @(negedge clk);
    enq2 = e; deq2 = d; key2 = k; val2 = v;
    @(posedge clk);
    #1;
    enq2 = 1'b0; deq2 = 1'b0;
  endtask

  int ek [4];
  int ev [4];
  int ek1 [4];
  int ev1 [4];

  initial begin
    rst_n = 1'b0;
    enq = 0; deq = 0; key = 0; val = 0;
    enq2 = 0; deq2 = 0; key2 = 0; val2 = 0;

    // Reset state
    #12;
    chk("rst_count", cnt0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_udf", udf0, 0);
    chk("rst_kvo_key", kk0, 0);
    chk("rst_kvo_val", kv0, 0);
    chk("rst_busy", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: stable ties
    op(1, 0, 8'd5, 8'd1);
    chk("t1_first_head", kk0, 5);
    op(1, 0, 8'd2, 8'd2);
    op(1, 0, 8'd7, 8'd3);
    op(1, 0, 8'd2, 8'd4);
    chk("t1_full", full0, 1);
    chk("t1_count", cnt0, 4);
    ek = '{2, 2, 5, 7};
    ev = '{2, 4, 1, 3};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_key%0d", i), kk0, ek[i]);
      chk($sformatf("t1_val%0d", i), kv0, ev[i]);
      op(0, 1, 8'd0, 8'd0);
    end
    chk("t1_empty", empty0, 1);
    chk("t1_kvo_empty", kk0, 0);

    // 2: overflow, reject vs drop-worst
    op(1, 0, 8'd1, 8'd10);
    op(1, 0, 8'd3, 8'd11);
    op(1, 0, 8'd5, 8'd12);
    op(1, 0, 8'd7, 8'd13);
    op(1, 0, 8'd4, 8'd99);
    chk("t2_ovf_rej", ovf0, 1);
    chk("t2_ovf_drop", ovf1, 1);
    chk("t2_cnt_rej", cnt0, 4);
    chk("t2_cnt_drop", cnt1, 4);
    op(0, 0, 8'd0, 8'd0);
    chk("t2_ovf_pulse", ovf0, 0);
    chk("t2_ovf_pulse_drop", ovf1, 0);
    // equal to tail is not strictly better: rejected by both
    op(1, 0, 8'd5, 8'd50);
    chk("t2_ovf_eq_drop", ovf1, 1);
    chk("t2_head_drop", kk1, 1);
    ek1 = '{1, 3, 4, 5};
    ev1 = '{10, 11, 99, 12};
    ev  = '{10, 11, 12, 13};
    ek  = '{1, 3, 5, 7};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_rej_key%0d", i), kk0, ek[i]);
      chk($sformatf("t2_rej_val%0d", i), kv0, ev[i]);
      chk($sformatf("t2_drop_key%0d", i), kk1, ek1[i]);
      chk($sformatf("t2_drop_val%0d", i), kv1, ev1[i]);
      op(0, 1, 8'd0, 8'd0);
    end
    chk("t2_empty_rej", empty0, 1);
    chk("t2_empty_drop", empty1, 1);

    // 3: replace
    op(1, 0, 8'd3, 8'd1);
    op(1, 0, 8'd6, 8'd2);
    op(1, 1, 8'd4, 8'd3);
    chk("t3_head_key", kk0, 4);
    chk("t3_head_val", kv0, 3);
    chk("t3_count", cnt0, 2);
    chk("t3_ovf", ovf0, 0);
    chk("t3_udf", udf0, 0);
    op(0, 1, 8'd0, 8'd0);
    chk("t3_second", kk0, 6);
    op(0, 1, 8'd0, 8'd0);
    chk("t3_empty", empty0, 1);

    // 4: underflow
    op(0, 1, 8'd0, 8'd0);
    chk("t4_udf", udf0, 1);
    chk("t4_count", cnt0, 0);
    chk("t4_kvo", kk0, 0);
    op(0, 0, 8'd0, 8'd0);
    chk("t4_udf_pulse", udf0, 0);
    op(1, 1, 8'd9, 8'd5);
    chk("t4_rep_empty_cnt", cnt0, 1);
    chk("t4_rep_empty_head", kk0, 9);
    chk("t4_rep_empty_udf", udf0, 1);
    op(0, 1, 8'd0, 8'd0);
    chk("t4_empty", empty0, 1);

    // 5: max-first
    op2(1, 0, 8'd5, 8'd1);
    op2(1, 0, 8'd2, 8'd2);
    op2(1, 0, 8'd7, 8'd3);
    chk("t5_count", cnt2, 3);
    ek = '{7, 5, 2, 0};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_key%0d", i), kk2, ek[i]);
      op2(0, 1, 8'd0, 8'd0);
    end
    chk("t5_empty", empty2, 1);

    // 6: async reset between edges
    op(1, 0, 8'd1, 8'd1);
    op(1, 0, 8'd2, 8'd2);
    op(1, 0, 8'd3, 8'd3);
    chk("t6_count_pre", cnt0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_count_rst", cnt0, 0);
    chk("t6_empty_rst", empty0, 1);
    chk("t6_kvo_rst", kk0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 0, 8'd8, 8'd4);
    chk("t6_count_post", cnt0, 1);
    chk("t6_head_post", kk0, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
